peak_frame_sequencer: RTL and testbench
=======================================

Name: peak_frame_sequencer

Overview:
- Frame-level controller in front of the FFT peak detector.
- Accepts a streaming magnitude source, arms the detector per frame with a one-cycle frame_start, forwards exactly FFT_SIZE samples, then waits for the detector's peak result.
- Applies a detection threshold and presents each frame's result on a valid/ready output.
- Supports single-shot and continuous modes, abort, and a watchdog timeout.

Parameters:
- INDEX_WIDTH, 11: bin index width; must satisfy 2^INDEX_WIDTH >= FFT_SIZE.
- WIDTH, 32: magnitude width.
- FFT_SIZE, 2048: samples per frame.
- TIMEOUT_CYCLES, 4096: maximum WAIT_PEAK dwell before error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a frame from IDLE
- continuous  in  1  level; re-arm automatically after each result
- abort  in  1  pulse; drop current frame, go IDLE
- threshold_in  in  WIDTH  detection threshold, sampled at capture
- mag_in  in  WIDTH  source magnitude
- mag_valid_in  in  1  source sample valid
- mag_ready_out  out  1  sequencer accepts sample (high only in STREAM)
- det_frame_start  out  1  to detector frame_start
- det_mag_out  out  WIDTH  to detector fft_magnitude_in
- det_valid_out  out  1  to detector valid_in
- det_peak_mag_in  in  WIDTH  detector peak magnitude
- det_peak_index_in  in  INDEX_WIDTH  detector peak index
- det_peak_valid_in  in  1  detector peak valid (level, cleared by frame_start)
- res_mag  out  WIDTH  captured peak magnitude
- res_index  out  INDEX_WIDTH  captured peak index
- res_above_thr  out  1  res_mag >= threshold at capture
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- busy  out  1  state != IDLE
- frame_count  out  16  completed result handshakes; wraps 65535 -> 0
- timeout_err  out  1  sticky; cleared only by reset or start

Behaviour:
- Reset (synchronous): state IDLE; every output 0, including res_* , frame_count and timeout_err. Reset mid-frame discards all progress; the detector is re-armed on the next frame via ARM.
- States:
  - IDLE: on start -> ARM; clear timeout_err.
  - ARM: det_frame_start=1 for exactly one cycle; mag_ready_out=0; bin counter := 0; -> STREAM.
  - STREAM: mag_ready_out=1. Each accepted sample (mag_valid_in & mag_ready_out) drives det_valid_out=1 and det_mag_out=mag_in combinationally, with zero latency, and increments the bin counter. On acceptance of sample FFT_SIZE-1 -> WAIT_PEAK. Gaps in mag_valid_in stall the frame without limit.
  - WAIT_PEAK: mag_ready_out=0; watchdog counts. When det_peak_valid_in=1: capture mag/index, compute res_above_thr with unsigned >=, -> HOLD. If the watchdog reaches TIMEOUT_CYCLES first: timeout_err=1, -> IDLE.
  - HOLD: res_valid=1; res_* stable until res_ready. On handshake, frame_count+1, then -> ARM if continuous=1, else -> IDLE.
- Latency: last sample accepted at cycle T; detector asserts peak valid at T+1; result captured at the T+1 edge; res_valid=1 from T+2.
- det_frame_start and det_valid_out are never high in the same cycle.
- det_peak_valid_in is ignored outside WAIT_PEAK. A stale high level from the prior frame is cleared by ARM before it can be sampled.
- continuous is sampled only at the HOLD handshake. Deasserting it mid-frame completes the current frame.
- abort in any non-IDLE state: -> IDLE next cycle; res_valid drops; frame_count and timeout_err unchanged. abort has priority over start and over the handshake in the same cycle.
- start outside IDLE is ignored.

Decomposition:
- Shared package: state enum (IDLE, ARM, STREAM, WAIT_PEAK, HOLD) and the frame_count width constant.
- Watchdog down-counter is the one natural sub-module: seq_watchdog (load, enable, expired).

Test Plan:
- FFT_SIZE=8, single-shot, samples 3,9,4,1,7,2,5,6 with res_ready=1 -> one det_frame_start pulse; 8 det_valid_out pulses; res_index/res_mag = detector output; res_valid at T+2; frame_count=1; busy drops afterwards.
- continuous=1, 3 frames, res_ready held low 5 cycles on frame 2 -> res_* stable throughout; mag_ready_out=0 during HOLD; frame_count=3.
- threshold_in=9 with peak 9, then peak 8 -> res_above_thr 1, then 0.
- det_peak_valid_in tied low, TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 WAIT_PEAK cycles; IDLE; next start clears timeout_err.
- abort after 4 samples, then start -> new ARM pulse; the next frame's index is counted from 0; no res_valid from the aborted frame.
- reset asserted mid-STREAM -> all outputs 0 the next cycle; the following start runs a clean frame.

Source files
------------

// File: rtl/peak_frame_sequencer_pkg.sv
// Shared types and constants for the peak frame sequencer.
package peak_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        WAIT_PEAK,
        HOLD
    } seq_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/peak_frame_sequencer_if.sv
// Source stream, detector link and result handshake of the sequencer.
// master: the sequencer side. slave: the environment (source, detector, consumer).
interface peak_frame_sequencer_if #(
    parameter int WIDTH       = 32,
    parameter int INDEX_WIDTH = 11
);
    logic [WIDTH-1:0]       mag_in;
    logic                   mag_valid_in;
    logic                   mag_ready_out;

    logic                   det_frame_start;
    logic [WIDTH-1:0]       det_mag_out;
    logic                   det_valid_out;
    logic [WIDTH-1:0]       det_peak_mag_in;
    logic [INDEX_WIDTH-1:0] det_peak_index_in;
    logic                   det_peak_valid_in;

    logic [WIDTH-1:0]       res_mag;
    logic [INDEX_WIDTH-1:0] res_index;
    logic                   res_above_thr;
    logic                   res_valid;
    logic                   res_ready;

    modport master (
        input  mag_in, mag_valid_in,
        input  det_peak_mag_in, det_peak_index_in, det_peak_valid_in,
        input  res_ready,
        output mag_ready_out,
        output det_frame_start, det_mag_out, det_valid_out,
        output res_mag, res_index, res_above_thr, res_valid
    );

    modport slave (
        output mag_in, mag_valid_in,
        output det_peak_mag_in, det_peak_index_in, det_peak_valid_in,
        output res_ready,
        input  mag_ready_out,
        input  det_frame_start, det_mag_out, det_valid_out,
        input  res_mag, res_index, res_above_thr, res_valid
    );
endinterface

// File: rtl/peak_frame_sequencer_watchdog.sv
// Down-counting watchdog: reloads while idle, counts while enabled,
// flags expiry on the last permitted cycle of the dwell.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expires in the TIMEOUT_CYCLES-th enabled cycle after a load.
    assign expired = enable && (cnt_q == '0);

    // Next count: reload has priority, then decrement, saturating at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (enable && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= RELOAD;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/peak_frame_sequencer.sv
// Frame controller in front of the FFT peak detector: arms the detector,
// forwards one frame of samples, captures and thresholds the peak result.
module peak_frame_sequencer
    import peak_frame_sequencer_pkg::*;
#(
    parameter int INDEX_WIDTH    = 11,
    parameter int WIDTH          = 32,
    parameter int FFT_SIZE       = 2048,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   continuous,
    input  logic                   abort,
    input  logic [WIDTH-1:0]       threshold_in,
    peak_frame_sequencer_if.master bus,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err
);
    localparam logic [INDEX_WIDTH-1:0] LAST_BIN = INDEX_WIDTH'(FFT_SIZE - 1);

    seq_state_t             state_q, state_d;
    logic [INDEX_WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0]       res_mag_q, res_mag_d;
    logic [INDEX_WIDTH-1:0] res_index_q, res_index_d;
    logic                   res_above_q, res_above_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   terr_q, terr_d;

    logic accept;
    logic wd_en;
    logic wd_expired;

    // Samples pass straight through to the detector in the accepting cycle.
    assign accept                = (state_q == STREAM) && bus.mag_valid_in;
    assign bus.mag_ready_out     = (state_q == STREAM);
    assign bus.det_valid_out     = accept;
    assign bus.det_mag_out       = accept ? bus.mag_in : '0;
    assign bus.det_frame_start   = (state_q == ARM);
    assign bus.res_valid         = (state_q == HOLD);
    assign bus.res_mag           = res_mag_q;
    assign bus.res_index         = res_index_q;
    assign bus.res_above_thr     = res_above_q;
    assign busy                  = (state_q != IDLE);
    assign frame_count           = fcnt_q;
    assign timeout_err           = terr_q;
    assign wd_en                 = (state_q == WAIT_PEAK);

    seq_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (!wd_en),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // Next-state and datapath updates; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        res_mag_d   = res_mag_q;
        res_index_d = res_index_q;
        res_above_d = res_above_q;
        fcnt_d      = fcnt_q;
        terr_d      = terr_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ARM;
                    terr_d  = 1'b0;
                end
            end
            ARM: begin
                bin_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (accept) begin
                    bin_d = bin_q + 1'b1;
                    if (bin_q == LAST_BIN)
                        state_d = WAIT_PEAK;
                end
            end
            WAIT_PEAK: begin
                // A peak arriving on the last watchdog cycle still counts.
                if (bus.det_peak_valid_in) begin
                    res_mag_d   = bus.det_peak_mag_in;
                    res_index_d = bus.det_peak_index_in;
                    res_above_d = (bus.det_peak_mag_in >= threshold_in);
                    state_d     = HOLD;
                end else if (wd_expired) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    fcnt_d  = fcnt_q + 1'b1;
                    state_d = continuous ? ARM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            res_mag_d   = res_mag_q;
            res_index_d = res_index_q;
            res_above_d = res_above_q;
            fcnt_d      = fcnt_q;
            terr_d      = terr_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            res_mag_q   <= '0;
            res_index_q <= '0;
            res_above_q <= 1'b0;
            fcnt_q      <= '0;
            terr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            res_mag_q   <= res_mag_d;
            res_index_q <= res_index_d;
            res_above_q <= res_above_d;
            fcnt_q      <= fcnt_d;
            terr_q      <= terr_d;
        end
    end
endmodule

// File: tb/tb_peak_frame_sequencer.sv
// Bench for peak_frame_sequencer with a behavioural peak detector.
module tb_peak_frame_sequencer;
    localparam int W   = 32;
    localparam int IW  = 3;
    localparam int FFT = 8;
    localparam int TO  = 16;

    typedef struct {
        logic [W-1:0]  s [FFT];
        logic [W-1:0]  thr;
        logic [W-1:0]  emag;
        logic [IW-1:0] eidx;
        logic          eabove;
    } vec_t;

    typedef struct {
        logic [W-1:0]  mag;
        logic [IW-1:0] idx;
        logic          above;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, continuous, abort;
    logic [W-1:0]  threshold_in;
    logic          busy, timeout_err;
    logic [15:0]   frame_count;

    peak_frame_sequencer_if #(.WIDTH(W), .INDEX_WIDTH(IW)) bus ();

    peak_frame_sequencer #(
        .INDEX_WIDTH(IW), .WIDTH(W), .FFT_SIZE(FFT), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .abort(abort), .threshold_in(threshold_in), .bus(bus),
        .busy(busy), .frame_count(frame_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural detector: tracks first maximum, peak valid the cycle after the last bin.
    bit          det_en = 1'b1;
    int          d_cnt  = 0;
    logic [W-1:0]  d_max = '0;
    logic [IW-1:0] d_idx = '0;
    bit          d_pv   = 1'b0;
    always @(posedge clk) begin
        if (bus.det_frame_start) begin
            d_cnt <= 0; d_max <= '0; d_idx <= '0; d_pv <= 1'b0;
        end else if (bus.det_valid_out && det_en) begin
            if (d_cnt == 0 || bus.det_mag_out > d_max) begin
                d_max <= bus.det_mag_out;
                d_idx <= IW'(d_cnt);
            end
            d_cnt <= d_cnt + 1;
            if (d_cnt == FFT - 1) d_pv <= 1'b1;
        end
    end
    assign bus.det_peak_mag_in   = d_max;
    assign bus.det_peak_index_in = d_idx;
    assign bus.det_peak_valid_in = d_pv;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [6];
    exp_t q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Output monitor / scoreboard.
    int   fs_cnt = 0, dv_cnt = 0, viol = 0, unstable = 0, lat = -1, last_acc = 0;
    bit   prev_rv = 0, prev_hs = 0;
    logic [W-1:0]  p_mag;
    logic [IW-1:0] p_idx;
    logic          p_abv;
    exp_t          e;
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.det_frame_start) fs_cnt++;
            if (bus.det_valid_out) begin dv_cnt++; last_acc = cyc; end
            if (bus.det_frame_start && bus.det_valid_out) viol++;
            if (bus.res_valid && bus.mag_ready_out) viol++;
            if (bus.res_valid && !prev_rv) lat = cyc - last_acc;
            if (bus.res_valid && prev_rv && !prev_hs &&
                (bus.res_mag !== p_mag || bus.res_index !== p_idx || bus.res_above_thr !== p_abv))
                unstable++;
            if (bus.res_valid && bus.res_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL res_unexpected act=%0h exp=none", bus.res_mag);
                end else begin
                    e = q.pop_front();
                    chk("res_mag", bus.res_mag, e.mag);
                    chk("res_index", 32'(bus.res_index), 32'(e.idx));
                    chk("res_above_thr", 32'(bus.res_above_thr), 32'(e.above));
                end
            end
            prev_rv = bus.res_valid;
            prev_hs = bus.res_valid && bus.res_ready;
            p_mag = bus.res_mag; p_idx = bus.res_index; p_abv = bus.res_above_thr;
        end else begin
            prev_rv = 0; prev_hs = 0;
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_fcnt"}, 32'(frame_count), 0);
        chk({nm, "_terr"}, 32'(timeout_err), 0);
        chk({nm, "_mrdy"}, 32'(bus.mag_ready_out), 0);
        chk({nm, "_fs"}, 32'(bus.det_frame_start), 0);
        chk({nm, "_dv"}, 32'(bus.det_valid_out), 0);
        chk({nm, "_dmag"}, bus.det_mag_out, 0);
        chk({nm, "_rmag"}, bus.res_mag, 0);
        chk({nm, "_ridx"}, 32'(bus.res_index), 0);
        chk({nm, "_rabv"}, 32'(bus.res_above_thr), 0);
        chk({nm, "_rvld"}, 32'(bus.res_valid), 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin @(posedge clk); #1; t++; end
        chk("idle_wait", 32'(t < 200), 1);
    endtask

    // Drive n samples of vector k; entered and left at #1 after an edge.
    task automatic send(input int k, input int n, input bit push, input bit clr_cont, input bit gap);
        int t;
        if (push) q.push_back('{vecs[k].emag, vecs[k].eidx, vecs[k].eabove});
        for (int i = 0; i < n; i++) begin
            if (gap && i == 3) begin
                bus.mag_valid_in = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
            bus.mag_in = vecs[k].s[i];
            bus.mag_valid_in = 1'b1;
            t = 0;
            while (!bus.mag_ready_out && t < 60) begin @(posedge clk); #1; t++; end
            if (t == 60) begin
                chk("ready_wait", 0, 1);
                bus.mag_valid_in = 1'b0;
                return;
            end
            if (i == 0) threshold_in = vecs[k].thr;
            if (clr_cont && i == 1) continuous = 1'b0;
            @(posedge clk); #1;
        end
        bus.mag_valid_in = 1'b0;
    endtask

    // Consumer: ready high except a 5-cycle stall on result number stall_f.
    task automatic ready_ctl(input int n, input int stall_f);
        int t;
        for (int f = 0; f < n; f++) begin
            bus.res_ready = (f != stall_f);
            t = 0;
            while (!bus.res_valid && t < 100) begin @(posedge clk); #1; t++; end
            if (t == 100) begin chk("res_valid_wait", 0, 1); return; end
            if (f == stall_f) begin
                repeat (5) begin @(posedge clk); #1; end
                chk("stall_res_valid", 32'(bus.res_valid), 1);
                chk("stall_mag_ready", 32'(bus.mag_ready_out), 0);
                bus.res_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
    endtask

    int ss [3];
    int k, fc0, fs0, dv0, n;

    initial begin
        vecs[0].s = '{32'd3, 32'd9, 32'd4, 32'd1, 32'd7, 32'd2, 32'd5, 32'd6};
        vecs[0].thr = 32'd5;   vecs[0].emag = 32'd9;   vecs[0].eidx = 3'd1; vecs[0].eabove = 1'b1;
        vecs[1].s = '{32'd1, 32'd2, 32'd9, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[1].thr = 32'd9;   vecs[1].emag = 32'd9;   vecs[1].eidx = 3'd2; vecs[1].eabove = 1'b1;
        vecs[2].s = '{32'd8, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
        vecs[2].thr = 32'd9;   vecs[2].emag = 32'd8;   vecs[2].eidx = 3'd0; vecs[2].eabove = 1'b0;
        vecs[3].s = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        vecs[3].thr = 32'd0;   vecs[3].emag = 32'd0;   vecs[3].eidx = 3'd0; vecs[3].eabove = 1'b1;
        vecs[4].s = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd10, 32'd11, 32'd200};
        vecs[4].thr = 32'd100; vecs[4].emag = 32'd200; vecs[4].eidx = 3'd7; vecs[4].eabove = 1'b1;
        vecs[5].s = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFE, 32'd4, 32'd5, 32'd6, 32'd7};
        vecs[5].thr = 32'hFFFF_FFFF; vecs[5].emag = 32'hFFFF_FFFE; vecs[5].eidx = 3'd3; vecs[5].eabove = 1'b0;
        ss = '{0, 4, 5};

        reset = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; threshold_in = '0;
        bus.mag_in = '0; bus.mag_valid_in = 1'b0; bus.res_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_zero("rst");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single-shot frames from the table.
        for (int j = 0; j < 3; j++) begin
            k = ss[j]; fc0 = frame_count; fs0 = fs_cnt; dv0 = dv_cnt;
            bus.res_ready = 1'b1;
            pulse_start();
            send(k, FFT, 1'b1, 1'b0, 1'b0);
            wait_idle();
            chk("ss_latency", 32'(lat), 2);
            chk("ss_fcnt", 32'(frame_count), 32'(fc0 + 1));
            chk("ss_fs_pulses", 32'(fs_cnt - fs0), 1);
            chk("ss_dv_pulses", 32'(dv_cnt - dv0), FFT);
            chk("ss_rvld", 32'(bus.res_valid), 0);
        end

        // Continuous: three frames, stall on the second, continuous dropped mid third.
        continuous = 1'b1; fc0 = frame_count; fs0 = fs_cnt;
        pulse_start();
        fork
            begin
                send(1, FFT, 1'b1, 1'b0, 1'b0);
                send(2, FFT, 1'b1, 1'b0, 1'b1);
                send(3, FFT, 1'b1, 1'b1, 1'b0);
            end
            ready_ctl(3, 1);
        join
        wait_idle();
        chk("cont_fcnt", 32'(frame_count), 32'(fc0 + 3));
        chk("cont_fs_pulses", 32'(fs_cnt - fs0), 3);
        chk("cont_busy", 32'(busy), 0);

        // Watchdog: detector silent.
        det_en = 1'b0; bus.res_ready = 1'b1; fc0 = frame_count;
        pulse_start();
        send(0, FFT, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!timeout_err && n < 40) begin @(posedge clk); #1; n++; end
        chk("wd_cycles", 32'(n), TO);
        chk("wd_terr", 32'(timeout_err), 1);
        chk("wd_busy", 32'(busy), 0);
        chk("wd_fcnt", 32'(frame_count), 32'(fc0));
        det_en = 1'b1;
        pulse_start();
        chk("wd_clear", 32'(timeout_err), 0);
        send(0, FFT, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("wd_next_fcnt", 32'(frame_count), 32'(fc0 + 1));

        // Abort after four samples.
        fc0 = frame_count;
        pulse_start();
        send(4, 4, 1'b0, 1'b0, 1'b0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rvld", 32'(bus.res_valid), 0);
        chk("abort_fcnt", 32'(frame_count), 32'(fc0));
        fs0 = fs_cnt;
        pulse_start();
        chk("abort_rearm", 32'(bus.det_frame_start), 1);
        send(0, FFT, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("abort_next_fcnt", 32'(frame_count), 32'(fc0 + 1));
        chk("abort_fs_pulses", 32'(fs_cnt - fs0), 1);

        // Reset in the middle of STREAM.
        pulse_start();
        send(5, 3, 1'b0, 1'b0, 1'b0);
        bus.mag_in = 32'h55; bus.mag_valid_in = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        reset = 1'b0; bus.mag_valid_in = 1'b0;
        pulse_start();
        send(0, FFT, 1'b1, 1'b0, 1'b0);
        wait_idle();
        chk("midrst_fcnt", 32'(frame_count), 1);

        repeat (3) @(posedge clk); #1;
        chk("queue_empty", 32'(q.size()), 0);
        chk("overlap_viol", 32'(viol), 0);
        chk("res_unstable", 32'(unstable), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end
endmodule
